ptw_walk_scheduler: RTL and testbench

//  Schedules ITLB and DTLB miss requests onto the single Sv32 page-table walker (PTW).

---
 rtl/ptw_sched_pkg.sv | 25 ++
 rtl/ptw_sched_slot.sv | 42 ++++
 rtl/ptw_walk_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_ptw_walk_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_sched_pkg.sv
// Shared types for the PTW walk scheduler: FSM states, miss request record, owner encoding.
package ptw_sched_pkg;

   localparam int unsigned PTW_VLEN   = 32;
   localparam int unsigned PTW_ASID_W = 9;

   localparam logic OWNER_DTLB = 1'b0;
   localparam logic OWNER_ITLB = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } sched_state_e;

   typedef struct packed {
      logic [PTW_VLEN-1:0]   vaddr;
      logic [PTW_ASID_W-1:0] asid;
      logic                  store;
   } miss_req_t;

   localparam int unsigned REQ_W = $bits(miss_req_t);

endpackage

// File: rtl/ptw_sched_slot.sv
// One-entry miss holding register; flush and clear win over load.
module ptw_sched_slot
   import ptw_sched_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic             flush_i,
   input  logic [REQ_W-1:0] data_i,
   output logic             valid_o,
   output logic [REQ_W-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [REQ_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i || clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/ptw_walk_scheduler.sv
// Arbitrates ITLB/DTLB misses onto one page-table walker and routes completions back.
// PTW_TIMEOUT_EN adds a WAIT/DRAIN watchdog that completes the walk with an error.
//
// state   | meaning
// S_IDLE  | no walk; pick a winner when any slot is valid
// S_ISSUE | ptw_valid_o high, winner fields held until ptw_ready_i
// S_WAIT  | walk in flight, owner gets *_done_o on completion
// S_DRAIN | flushed walk in flight, completion swallowed
module ptw_walk_scheduler
   import ptw_sched_pkg::*;
#(
   parameter int unsigned VLEN           = PTW_VLEN,
   parameter int unsigned ASID_WIDTH     = PTW_ASID_W,
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  itlb_req_i,
   input  logic [VLEN-1:0]       itlb_vaddr_i,
   input  logic [ASID_WIDTH-1:0] itlb_asid_i,
   output logic                  itlb_ack_o,
   input  logic                  dtlb_req_i,
   input  logic [VLEN-1:0]       dtlb_vaddr_i,
   input  logic [ASID_WIDTH-1:0] dtlb_asid_i,
   input  logic                  dtlb_store_i,
   output logic                  dtlb_ack_o,
   output logic                  ptw_valid_o,
   input  logic                  ptw_ready_i,
   output logic [VLEN-1:0]       ptw_vaddr_o,
   output logic [ASID_WIDTH-1:0] ptw_asid_o,
   output logic                  ptw_instr_o,
   output logic                  ptw_store_o,
   input  logic                  ptw_done_i,
   input  logic                  ptw_error_i,
   output logic                  itlb_done_o,
   output logic                  dtlb_done_o,
   output logic                  walk_error_o,
   output logic                  busy_o
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   miss_req_t     i_in, d_in, i_req, d_req, walk_q, walk_d;
   logic          i_valid, d_valid, i_clear, d_clear;
   sched_state_e  state_q, state_d;
   logic          owner_q, owner_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          ptw_valid_q, ptw_valid_d;
   logic          itlb_done_q, itlb_done_d, dtlb_done_q, dtlb_done_d;
   logic          walk_err_q, walk_err_d;
   logic          pick_itlb, hs, cmpl, tmo_hit;

   assign i_in = '{vaddr: itlb_vaddr_i, asid: itlb_asid_i, store: 1'b0};
   assign d_in = '{vaddr: dtlb_vaddr_i, asid: dtlb_asid_i, store: dtlb_store_i};

   assign itlb_ack_o = itlb_req_i & ~i_valid & ~flush_i;
   assign dtlb_ack_o = dtlb_req_i & ~d_valid & ~flush_i;

   ptw_sched_slot u_itlb_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (itlb_ack_o),
      .clear_i (i_clear),
      .flush_i (flush_i),
      .data_i  (i_in),
      .valid_o (i_valid),
      .data_o  (i_req)
   );

   ptw_sched_slot u_dtlb_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (dtlb_ack_o),
      .clear_i (d_clear),
      .flush_i (flush_i),
      .data_i  (d_in),
      .valid_o (d_valid),
      .data_o  (d_req)
   );

`ifdef PTW_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;

   // Reloaded on every state change, so it measures cycles spent in the current WAIT/DRAIN.
   assign tmo_hit = ((state_q == S_WAIT) || (state_q == S_DRAIN)) && (tmo_q == '0);

   always_comb begin
      tmo_d = tmo_q;
      if (state_d != state_q) tmo_d = TW'(TIMEOUT_CYCLES - 1);
      else if (tmo_q != '0)   tmo_d = tmo_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

   assign pick_itlb = i_valid & (~d_valid | (starve_q == SW'(STARVE_LIMIT)));
   assign hs        = ptw_valid_q & ptw_ready_i;
   assign cmpl      = ptw_done_i | ptw_error_i;

   always_comb begin
      state_d     = state_q;
      walk_d      = walk_q;
      owner_d     = owner_q;
      starve_d    = starve_q;
      i_clear     = 1'b0;
      d_clear     = 1'b0;
      itlb_done_d = 1'b0;
      dtlb_done_d = 1'b0;
      walk_err_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!flush_i && (i_valid || d_valid)) begin
               state_d = S_ISSUE;
               if (pick_itlb) begin
                  owner_d  = OWNER_ITLB;
                  walk_d   = i_req;
                  starve_d = '0;
               end else begin
                  owner_d = OWNER_DTLB;
                  walk_d  = d_req;
                  if (i_valid && (starve_q != SW'(STARVE_LIMIT))) starve_d = starve_q + 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (flush_i) begin
               state_d = hs ? S_DRAIN : S_IDLE;
            end else if (hs) begin
               state_d = S_WAIT;
               i_clear = (owner_q == OWNER_ITLB);
               d_clear = (owner_q == OWNER_DTLB);
            end
         end
         S_WAIT: begin
            // A completion racing a flush has nothing left to drain.
            if (cmpl || tmo_hit) begin
               state_d = S_IDLE;
               if (!flush_i) begin
                  itlb_done_d = (owner_q == OWNER_ITLB);
                  dtlb_done_d = (owner_q == OWNER_DTLB);
                  walk_err_d  = ptw_error_i | ~cmpl;
               end
            end else if (flush_i) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (cmpl || tmo_hit) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      ptw_valid_d = (state_d == S_ISSUE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         walk_q      <= '0;
         owner_q     <= OWNER_DTLB;
         starve_q    <= '0;
         ptw_valid_q <= 1'b0;
         itlb_done_q <= 1'b0;
         dtlb_done_q <= 1'b0;
         walk_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         walk_q      <= walk_d;
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         ptw_valid_q <= ptw_valid_d;
         itlb_done_q <= itlb_done_d;
         dtlb_done_q <= dtlb_done_d;
         walk_err_q  <= walk_err_d;
      end
   end

   assign ptw_valid_o  = ptw_valid_q;
   assign ptw_vaddr_o  = walk_q.vaddr;
   assign ptw_asid_o   = walk_q.asid;
   assign ptw_store_o  = walk_q.store;
   assign ptw_instr_o  = owner_q;
   assign itlb_done_o  = itlb_done_q;
   assign dtlb_done_o  = dtlb_done_q;
   assign walk_error_o = walk_err_q;
   assign busy_o       = (state_q != S_IDLE) | i_valid | d_valid;

endmodule

// File: tb/tb_ptw_walk_scheduler.sv
// Scoreboard bench for ptw_walk_scheduler: directed misses, a PTW responder and a decoupled monitor.
module tb_ptw_walk_scheduler;

   typedef struct packed {
      logic [31:0] va;
      logic [8:0]  asid;
      logic        instr;
      logic        st;
   } walk_t;

   typedef struct packed {
      logic i;
      logic d;
      logic e;
   } done_t;

   logic        clk_i = 1'b0;
   logic        rst_i, flush_i;
   logic        itlb_req_i, dtlb_req_i, dtlb_store_i, ptw_ready_i;
   logic [31:0] itlb_vaddr_i, dtlb_vaddr_i;
   logic [8:0]  itlb_asid_i, dtlb_asid_i;
   logic        ptw_done_i, ptw_error_i;
   logic        itlb_ack_o, dtlb_ack_o, ptw_valid_o, ptw_instr_o, ptw_store_o;
   logic [31:0] ptw_vaddr_o;
   logic [8:0]  ptw_asid_o;
   logic        itlb_done_o, dtlb_done_o, walk_error_o, busy_o;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    resp_lat = 3;
   logic  resp_err = 1'b0;
   walk_t exp_walk[$];
   done_t exp_done[$];

   always #5 clk_i = ~clk_i;

   ptw_walk_scheduler dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .itlb_req_i(itlb_req_i), .itlb_vaddr_i(itlb_vaddr_i), .itlb_asid_i(itlb_asid_i), .itlb_ack_o(itlb_ack_o),
      .dtlb_req_i(dtlb_req_i), .dtlb_vaddr_i(dtlb_vaddr_i), .dtlb_asid_i(dtlb_asid_i),
      .dtlb_store_i(dtlb_store_i), .dtlb_ack_o(dtlb_ack_o),
      .ptw_valid_o(ptw_valid_o), .ptw_ready_i(ptw_ready_i), .ptw_vaddr_o(ptw_vaddr_o),
      .ptw_asid_o(ptw_asid_o), .ptw_instr_o(ptw_instr_o), .ptw_store_o(ptw_store_o),
      .ptw_done_i(ptw_done_i), .ptw_error_i(ptw_error_i),
      .itlb_done_o(itlb_done_o), .dtlb_done_o(dtlb_done_o), .walk_error_o(walk_error_o), .busy_o(busy_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_walk(input logic [31:0] va, input logic [8:0] asid, input logic instr, input logic st);
      exp_walk.push_back('{va: va, asid: asid, instr: instr, st: st});
   endtask

   task automatic push_done(input logic i, input logic d, input logic e);
      exp_done.push_back('{i: i, d: d, e: e});
   endtask

   // PTW model: completes each accepted walk resp_lat cycles after the handshake edge.
   initial begin
      ptw_done_i  = 1'b0;
      ptw_error_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_i && ptw_valid_o && ptw_ready_i) begin
            repeat (resp_lat) @(posedge clk_i);
            #1;
            ptw_done_i  = 1'b1;
            ptw_error_i = resp_err;
            @(posedge clk_i);
            #1;
            ptw_done_i  = 1'b0;
            ptw_error_i = 1'b0;
         end
      end
   end

   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (ptw_valid_o && ptw_ready_i) begin
            if (exp_walk.size() == 0) begin
               check("walk_unexpected", 64'(ptw_vaddr_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               walk_t w;
               w = exp_walk.pop_front();
               check("walk_vaddr", 64'(ptw_vaddr_o), 64'(w.va));
               check("walk_asid",  64'(ptw_asid_o),  64'(w.asid));
               check("walk_instr", 64'(ptw_instr_o), 64'(w.instr));
               check("walk_store", 64'(ptw_store_o), 64'(w.st));
            end
         end
         if (itlb_done_o || dtlb_done_o || walk_error_o) begin
            if (exp_done.size() == 0) begin
               check("done_unexpected", 64'({itlb_done_o, dtlb_done_o, walk_error_o}), 64'd0);
            end else begin
               done_t e;
               e = exp_done.pop_front();
               check("done_i_d_err", 64'({itlb_done_o, dtlb_done_o, walk_error_o}), 64'(e));
            end
         end
      end
   end

   task automatic send_d(input logic [31:0] va, input logic [8:0] asid, input logic st);
      bit got = 1'b0;
      dtlb_req_i = 1'b1; dtlb_vaddr_i = va; dtlb_asid_i = asid; dtlb_store_i = st;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk_i);
         got = dtlb_ack_o;
      end
      @(posedge clk_i); #1;
      dtlb_req_i = 1'b0;
      check("dtlb_ack", 64'(got), 64'd1);
   endtask

   task automatic send_i(input logic [31:0] va, input logic [8:0] asid);
      bit got = 1'b0;
      itlb_req_i = 1'b1; itlb_vaddr_i = va; itlb_asid_i = asid;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk_i);
         got = itlb_ack_o;
      end
      @(posedge clk_i); #1;
      itlb_req_i = 1'b0;
      check("itlb_ack", 64'(got), 64'd1);
   endtask

   task automatic send_both(input logic [31:0] iva, input logic [8:0] iasid,
                            input logic [31:0] dva, input logic [8:0] dasid);
      itlb_req_i = 1'b1; itlb_vaddr_i = iva; itlb_asid_i = iasid;
      dtlb_req_i = 1'b1; dtlb_vaddr_i = dva; dtlb_asid_i = dasid; dtlb_store_i = 1'b0;
      @(negedge clk_i);
      check("both_acks", 64'({itlb_ack_o, dtlb_ack_o}), 64'b11);
      @(posedge clk_i); #1;
      itlb_req_i = 1'b0;
      dtlb_req_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit idle = 1'b0;
      for (int k = 0; k < 400 && !idle; k++) begin
         @(negedge clk_i);
         idle = !busy_o;
      end
      check(name, 64'(busy_o), 64'd0);
      @(posedge clk_i); #1;
   endtask

   task automatic wait_valid(input bit need_ready, output bit seen);
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk_i);
         seen = ptw_valid_o && (!need_ready || ptw_ready_i);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      rst_i = 1'b1; flush_i = 1'b0; ptw_ready_i = 1'b1;
      itlb_req_i = 1'b0; itlb_vaddr_i = '0; itlb_asid_i = '0;
      dtlb_req_i = 1'b0; dtlb_vaddr_i = '0; dtlb_asid_i = '0; dtlb_store_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_ptw_valid", 64'(ptw_valid_o), 64'd0);
      check("rst_done", 64'({itlb_done_o, dtlb_done_o, walk_error_o}), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_instr_store", 64'({ptw_instr_o, ptw_store_o}), 64'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // Single DTLB miss.
      push_walk(32'h0000_A000, 9'd1, 1'b0, 1'b0);
      push_done(1'b0, 1'b1, 1'b0);
      send_d(32'h0000_A000, 9'd1, 1'b0);
      wait_idle("t1_busy_drop");

      // Simultaneous ITLB and DTLB: DTLB first.
      push_walk(32'h0000_B000, 9'd8, 1'b0, 1'b0);
      push_walk(32'h0040_0000, 9'd7, 1'b1, 1'b0);
      push_done(1'b0, 1'b1, 1'b0);
      push_done(1'b1, 1'b0, 1'b0);
      send_both(32'h0040_0000, 9'd7, 32'h0000_B000, 9'd8);
      wait_idle("t2_idle");

      // Starvation limit: ITLB after the fourth DTLB walk.
      for (int n = 1; n <= 4; n++) push_walk(32'(n) << 12, 9'd2, 1'b0, n == 3);
      push_walk(32'h0060_0000, 9'd5, 1'b1, 1'b0);
      push_walk(32'h0000_5000, 9'd2, 1'b0, 1'b0);
      push_walk(32'h0000_6000, 9'd2, 1'b0, 1'b0);
      for (int n = 0; n < 4; n++) push_done(1'b0, 1'b1, 1'b0);
      push_done(1'b1, 1'b0, 1'b0);
      push_done(1'b0, 1'b1, 1'b0);
      push_done(1'b0, 1'b1, 1'b0);
      send_both(32'h0060_0000, 9'd5, 32'h0000_1000, 9'd2);
      for (int n = 2; n <= 6; n++) send_d(32'(n) << 12, 9'd2, n == 3);
      wait_idle("t3_idle");

      // Flush while ISSUE is stalled on ptw_ready_i: request withdrawn.
      ptw_ready_i = 1'b0;
      send_d(32'h0000_E000, 9'd4, 1'b1);
      wait_valid(1'b0, seen);
      check("issue_seen", 64'(seen), 64'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         check("issue_hold", 64'({ptw_valid_o, ptw_store_o, ptw_vaddr_o}), {31'd0, 1'b1, 1'b1, 32'h0000_E000});
      end
      @(posedge clk_i); #1;
      flush_i = 1'b1; dtlb_req_i = 1'b1; dtlb_vaddr_i = 32'h0000_F000;
      @(negedge clk_i);
      check("flush_noack", 64'(dtlb_ack_o), 64'd0);
      @(posedge clk_i); #1;
      flush_i = 1'b0; dtlb_req_i = 1'b0;
      @(negedge clk_i);
      check("withdrawn", 64'({ptw_valid_o, busy_o}), 64'd0);
      @(posedge clk_i); #1;
      ptw_ready_i = 1'b1;

      // Flush in WAIT: completion swallowed, next miss normal.
      push_walk(32'h0000_C000, 9'd6, 1'b0, 1'b0);
      send_d(32'h0000_C000, 9'd6, 1'b0);
      wait_valid(1'b1, seen);
      check("t4_hs_seen", 64'(seen), 64'd1);
      @(posedge clk_i); #1;
      flush_i = 1'b1; dtlb_req_i = 1'b1; dtlb_vaddr_i = 32'h0000_F000;
      @(negedge clk_i);
      check("t4_flush_noack", 64'(dtlb_ack_o), 64'd0);
      @(posedge clk_i); #1;
      flush_i = 1'b0; dtlb_req_i = 1'b0;
      wait_idle("t4_drained");
      push_walk(32'h0000_D000, 9'd6, 1'b0, 1'b1);
      push_done(1'b0, 1'b1, 1'b0);
      send_d(32'h0000_D000, 9'd6, 1'b1);
      wait_idle("t4_after");

      // done and error together on an ITLB walk.
      resp_err = 1'b1;
      push_walk(32'h0050_0000, 9'd3, 1'b1, 1'b0);
      push_done(1'b1, 1'b0, 1'b1);
      send_i(32'h0050_0000, 9'd3);
      wait_idle("t5_idle");
      resp_err = 1'b0;

      repeat (3) @(posedge clk_i);
      check("walks_left", 64'(exp_walk.size()), 64'd0);
      check("dones_left", 64'(exp_done.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
